// File: rtl/viola_pkg.sv
// Shared ROB/reservation-station constants and the wrapping tag-pointer increment.
package viola_pkg;

  localparam int unsigned TAG_W  = 3;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NO_TAG = 0;

  // Tag 0 means "no tag", so pointers wrap from max_idx back to 1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned max_idx);
    return (ptr >= max_idx) ? 32'd1 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: allocation, writeback capture, head read and two operand query ports.
// Define ROB_BYPASS_EN to let queries see same-cycle writeback buses.
module rob_entry_array import viola_pkg::*; #(
  parameter int unsigned TAG_W = viola_pkg::TAG_W,
  parameter int unsigned XLEN  = viola_pkg::XLEN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pause,
  input  logic             i_flush,
  input  logic             i_alloc,
  input  logic [TAG_W-1:0] i_alloc_tag,
  input  logic [4:0]       i_alloc_rd,
  input  logic             i_free,
  input  logic [TAG_W-1:0] i_head_tag,
  input  logic [TAG_W-1:0] i_alu_tag,
  input  logic [XLEN-1:0]  i_alu_data,
  input  logic [TAG_W-1:0] i_mem_tag,
  input  logic [XLEN-1:0]  i_mem_data,
  input  logic [TAG_W-1:0] i_query1,
  input  logic [TAG_W-1:0] i_query2,
  output logic             o_q1_ready,
  output logic [XLEN-1:0]  o_q1_data,
  output logic             o_q2_ready,
  output logic [XLEN-1:0]  o_q2_data,
  output logic             o_head_busy,
  output logic             o_head_ready,
  output logic [4:0]       o_head_rd,
  output logic [XLEN-1:0]  o_head_data
);

  localparam int unsigned ENTRIES = (1 << TAG_W) - 1;

  // Slot 0 exists only so any tag indexes safely; it is never allocated.
  logic            r_busy  [0:ENTRIES];
  logic            r_ready [0:ENTRIES];
  logic [4:0]      r_rd    [0:ENTRIES];
  logic [XLEN-1:0] r_data  [0:ENTRIES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= int'(ENTRIES); i++) begin
        r_busy[i]  <= 1'b0;
        r_ready[i] <= 1'b0;
        r_rd[i]    <= '0;
        r_data[i]  <= '0;
      end
    end else if (!i_pause) begin
      for (int i = 0; i <= int'(ENTRIES); i++) begin
        if (i_flush) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end else if (i_alloc && i_alloc_tag == TAG_W'(i)) begin
          r_busy[i]  <= 1'b1;
          r_ready[i] <= 1'b0;
          r_rd[i]    <= i_alloc_rd;
        end else if (i_free && i_head_tag == TAG_W'(i)) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end else if (r_busy[i] && i_mem_tag == TAG_W'(i)) begin
          r_ready[i] <= 1'b1;
          r_data[i]  <= i_mem_data;
        end else if (r_busy[i] && i_alu_tag == TAG_W'(i)) begin
          r_ready[i] <= 1'b1;
          r_data[i]  <= i_alu_data;
        end
      end
    end
  end

  logic [TAG_W-1:0] w_qtag [2];
  logic             w_qrdy [2];
  logic [XLEN-1:0]  w_qdat [2];

  assign w_qtag[0] = i_query1;
  assign w_qtag[1] = i_query2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_qrdy[p] = 1'b0;
      w_qdat[p] = '0;
      if (w_qtag[p] == TAG_W'(NO_TAG)) begin
        w_qrdy[p] = 1'b1;
`ifdef ROB_BYPASS_EN
      end else if (w_qtag[p] == i_mem_tag) begin
        w_qrdy[p] = 1'b1;
        w_qdat[p] = i_mem_data;
      end else if (w_qtag[p] == i_alu_tag) begin
        w_qrdy[p] = 1'b1;
        w_qdat[p] = i_alu_data;
`endif
      end else if (r_busy[w_qtag[p]] && r_ready[w_qtag[p]]) begin
        w_qrdy[p] = 1'b1;
        w_qdat[p] = r_data[w_qtag[p]];
      end
    end
  end

  assign o_q1_ready   = w_qrdy[0];
  assign o_q1_data    = w_qdat[0];
  assign o_q2_ready   = w_qrdy[1];
  assign o_q2_data    = w_qdat[1];
  assign o_head_busy  = r_busy[i_head_tag];
  assign o_head_ready = r_ready[i_head_tag];
  assign o_head_rd    = r_rd[i_head_tag];
  assign o_head_data  = r_data[i_head_tag];

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer top: head/tail pointers, occupancy count and registered in-order commit.
// Optional ROB_BYPASS_EN enables writeback-to-query bypass in the entry array.
module reorder_buffer import viola_pkg::*; #(
  parameter int unsigned TAG_W = viola_pkg::TAG_W,
  parameter int unsigned XLEN  = viola_pkg::XLEN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pause,
  input  logic             i_flush,
  input  logic             i_disp_valid,
  input  logic [4:0]       i_disp_rd,
  output logic [TAG_W-1:0] o_disp_tag,
  input  logic [TAG_W-1:0] i_alu_des_in,
  input  logic [XLEN-1:0]  i_alu_data,
  input  logic [TAG_W-1:0] i_memory_des_in,
  input  logic [XLEN-1:0]  i_memory_data,
  input  logic [TAG_W-1:0] i_query1,
  input  logic [TAG_W-1:0] i_query2,
  output logic             o_q1_ready,
  output logic [XLEN-1:0]  o_q1_data,
  output logic             o_q2_ready,
  output logic [XLEN-1:0]  o_q2_data,
  output logic             o_commit_valid,
  output logic [4:0]       o_commit_rd,
  output logic [TAG_W-1:0] o_commit_tag,
  output logic [XLEN-1:0]  o_commit_data,
  output logic             o_rob_full,
  output logic             o_rob_empty
);

  localparam int unsigned ENTRIES = (1 << TAG_W) - 1;

  logic [TAG_W-1:0] r_head, r_tail, r_count, r_commit_tag;
  logic             r_full, r_empty, r_commit_valid;
  logic [4:0]       r_commit_rd;
  logic [XLEN-1:0]  r_commit_data;

  logic [TAG_W-1:0] w_head_nxt, w_tail_nxt, w_count_nxt, w_ctag_nxt;
  logic             w_full_nxt, w_empty_nxt, w_cv_nxt;
  logic [4:0]       w_crd_nxt;
  logic [XLEN-1:0]  w_cdata_nxt;

  logic             w_alloc, w_commit, w_head_busy, w_head_ready;
  logic [4:0]       w_head_rd;
  logic [XLEN-1:0]  w_head_data;

  // Registered full flag gates dispatch, so a commit never frees a slot for the same cycle.
  assign w_alloc  = i_disp_valid & ~r_full & ~i_pause & ~i_flush;
  assign w_commit = w_head_busy & w_head_ready & ~i_pause & ~i_flush;

  rob_entry_array #(
    .TAG_W (TAG_W),
    .XLEN  (XLEN)
  ) u_entries (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pause      (i_pause),
    .i_flush      (i_flush),
    .i_alloc      (w_alloc),
    .i_alloc_tag  (r_tail),
    .i_alloc_rd   (i_disp_rd),
    .i_free       (w_commit),
    .i_head_tag   (r_head),
    .i_alu_tag    (i_alu_des_in),
    .i_alu_data   (i_alu_data),
    .i_mem_tag    (i_memory_des_in),
    .i_mem_data   (i_memory_data),
    .i_query1     (i_query1),
    .i_query2     (i_query2),
    .o_q1_ready   (o_q1_ready),
    .o_q1_data    (o_q1_data),
    .o_q2_ready   (o_q2_ready),
    .o_q2_data    (o_q2_data),
    .o_head_busy  (w_head_busy),
    .o_head_ready (w_head_ready),
    .o_head_rd    (w_head_rd),
    .o_head_data  (w_head_data)
  );

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    w_full_nxt  = r_full;
    w_empty_nxt = r_empty;
    w_cv_nxt    = r_commit_valid;
    w_crd_nxt   = r_commit_rd;
    w_ctag_nxt  = r_commit_tag;
    w_cdata_nxt = r_commit_data;
    if (!i_pause) begin
      if (i_flush) begin
        w_head_nxt  = TAG_W'(1);
        w_tail_nxt  = TAG_W'(1);
        w_count_nxt = '0;
        w_full_nxt  = 1'b0;
        w_empty_nxt = 1'b1;
        w_cv_nxt    = 1'b0;
        w_crd_nxt   = '0;
        w_ctag_nxt  = '0;
        w_cdata_nxt = '0;
      end else begin
        if (w_alloc)  w_tail_nxt = TAG_W'(ptr_inc(32'(r_tail), ENTRIES));
        if (w_commit) w_head_nxt = TAG_W'(ptr_inc(32'(r_head), ENTRIES));
        w_count_nxt = r_count + TAG_W'(w_alloc) - TAG_W'(w_commit);
        w_full_nxt  = (w_count_nxt == TAG_W'(ENTRIES));
        w_empty_nxt = (w_count_nxt == '0);
        w_cv_nxt    = w_commit;
        w_crd_nxt   = w_commit ? w_head_rd   : '0;
        w_ctag_nxt  = w_commit ? r_head      : '0;
        w_cdata_nxt = w_commit ? w_head_data : '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head         <= TAG_W'(1);
      r_tail         <= TAG_W'(1);
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_tag   <= '0;
      r_commit_data  <= '0;
    end else begin
      r_head         <= w_head_nxt;
      r_tail         <= w_tail_nxt;
      r_count        <= w_count_nxt;
      r_full         <= w_full_nxt;
      r_empty        <= w_empty_nxt;
      r_commit_valid <= w_cv_nxt;
      r_commit_rd    <= w_crd_nxt;
      r_commit_tag   <= w_ctag_nxt;
      r_commit_data  <= w_cdata_nxt;
    end
  end

  assign o_disp_tag     = r_tail;
  assign o_commit_valid = r_commit_valid;
  assign o_commit_rd    = r_commit_rd;
  assign o_commit_tag   = r_commit_tag;
  assign o_commit_data  = r_commit_data;
  assign o_rob_full     = r_full;
  assign o_rob_empty    = r_empty;

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer against an in-order queue model of the ROB.
// Query expectations follow ROB_BYPASS_EN when the macro is defined.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n, pause, flush, disp_valid;
  logic [4:0]  disp_rd;
  logic [2:0]  disp_tag;
  logic [2:0]  alu_tag, mem_tag, query1, query2;
  logic [31:0] alu_data, mem_data;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        commit_valid, rob_full, rob_empty;
  logic [4:0]  commit_rd;
  logic [2:0]  commit_tag;
  logic [31:0] commit_data;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pause         (pause),
    .i_flush         (flush),
    .i_disp_valid    (disp_valid),
    .i_disp_rd       (disp_rd),
    .o_disp_tag      (disp_tag),
    .i_alu_des_in    (alu_tag),
    .i_alu_data      (alu_data),
    .i_memory_des_in (mem_tag),
    .i_memory_data   (mem_data),
    .i_query1        (query1),
    .i_query2        (query2),
    .o_q1_ready      (q1_ready),
    .o_q1_data       (q1_data),
    .o_q2_ready      (q2_ready),
    .o_q2_data       (q2_data),
    .o_commit_valid  (commit_valid),
    .o_commit_rd     (commit_rd),
    .o_commit_tag    (commit_tag),
    .o_commit_data   (commit_data),
    .o_rob_full      (rob_full),
    .o_rob_empty     (rob_empty)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: program-order queue of live tags plus per-tag contents.
  int          mq[$];
  bit          m_busy  [8];
  bit          m_ready [8];
  logic [31:0] m_data  [8];
  logic [4:0]  m_rd    [8];
  int          m_tail;
  logic        e_cv, e_full, e_empty;
  logic [4:0]  e_crd;
  logic [2:0]  e_ctag;
  logic [31:0] e_cdata;

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < 8; i++) begin
      m_busy[i]  = 1'b0;
      m_ready[i] = 1'b0;
    end
    m_tail  = 1;
    e_cv    = 1'b0;
    e_crd   = '0;
    e_ctag  = '0;
    e_cdata = '0;
    e_full  = 1'b0;
    e_empty = 1'b1;
  endfunction

  function automatic void model_edge();
    bit do_commit, do_alloc;
    int h;
    if (!rst_n) begin
      model_reset();
    end else if (pause) begin
      // everything holds
    end else if (flush) begin
      model_reset();
    end else begin
      do_commit = (mq.size() > 0) && m_ready[mq[0]];
      do_alloc  = disp_valid && (mq.size() < 7);
      e_cv = do_commit; e_crd = '0; e_ctag = '0; e_cdata = '0;
      if (do_commit) begin
        h       = mq[0];
        e_crd   = m_rd[h];
        e_ctag  = 3'(h);
        e_cdata = m_data[h];
      end
      if (alu_tag != 0 && m_busy[alu_tag]) begin
        m_ready[alu_tag] = 1'b1;
        m_data[alu_tag]  = alu_data;
      end
      if (mem_tag != 0 && m_busy[mem_tag]) begin
        m_ready[mem_tag] = 1'b1;
        m_data[mem_tag]  = mem_data;
      end
      if (do_commit) begin
        h = mq.pop_front();
        m_busy[h]  = 1'b0;
        m_ready[h] = 1'b0;
      end
      if (do_alloc) begin
        mq.push_back(m_tail);
        m_busy[m_tail]  = 1'b1;
        m_ready[m_tail] = 1'b0;
        m_rd[m_tail]    = disp_rd;
        m_tail          = m_tail % 7 + 1;
      end
      e_full  = (mq.size() == 7);
      e_empty = (mq.size() == 0);
    end
  endfunction

  function automatic void exp_query(input logic [2:0] q, output logic r, output logic [31:0] d);
    r = 1'b0;
    d = '0;
    if (q == 0) r = 1'b1;
`ifdef ROB_BYPASS_EN
    else if (q == mem_tag) begin r = 1'b1; d = mem_data; end
    else if (q == alu_tag) begin r = 1'b1; d = alu_data; end
`endif
    else if (m_busy[q] && m_ready[q]) begin r = 1'b1; d = m_data[q]; end
  endfunction

  task automatic tick();
    logic        r;
    logic [31:0] d;
    @(negedge clk);
    check("disp_tag", disp_tag, 64'(m_tail));
    exp_query(query1, r, d);
    check("q1_ready", q1_ready, r);
    check("q1_data", q1_data, d);
    exp_query(query2, r, d);
    check("q2_ready", q2_ready, r);
    check("q2_data", q2_data, d);
    @(posedge clk);
    model_edge();
    #1;
    check("commit_valid", commit_valid, e_cv);
    check("commit_rd", commit_rd, e_crd);
    check("commit_tag", commit_tag, e_ctag);
    check("commit_data", commit_data, e_cdata);
    check("rob_full", rob_full, e_full);
    check("rob_empty", rob_empty, e_empty);
  endtask

  task automatic set_idle();
    rst_n = 1'b1; pause = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_rd = '0;
    alu_tag = '0; alu_data = '0; mem_tag = '0; mem_data = '0; query1 = '0; query2 = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    set_idle();
  endtask

  task automatic dispatch(input int n);
    for (int i = 0; i < n; i++) begin
      disp_valid = 1'b1;
      disp_rd    = 5'(i + 1);
      tick();
    end
    set_idle();
  endtask

  initial begin
    model_reset();
    do_reset();
    check("rst_empty", rob_empty, 1);
    check("rst_full", rob_full, 0);
    check("rst_cv", commit_valid, 0);

    // Single dispatch, ALU writeback, commit one edge later
    disp_valid = 1'b1; disp_rd = 5'd5;
    check("first_tag", disp_tag, 1);
    tick(); set_idle();
    alu_tag = 3'd1; alu_data = 32'hAA;
    tick(); set_idle();
    tick();
    check("c1_valid", commit_valid, 1);
    check("c1_rd", commit_rd, 5);
    check("c1_data", commit_data, 32'hAA);
    tick();
    check("c1_strobe", commit_valid, 0);

    // Fill to full, extra dispatch dropped, tail wrapped to 1
    do_reset();
    dispatch(7);
    check("full_set", rob_full, 1);
    check("full_tail", disp_tag, 1);
    disp_valid = 1'b1; disp_rd = 5'd31;
    tick(); set_idle();
    check("full_drop", disp_tag, 1);

    // Out-of-order writeback, in-order commit
    do_reset();
    dispatch(2);
    alu_tag = 3'd2; alu_data = 32'h22; tick(); set_idle();
    mem_tag = 3'd1; mem_data = 32'h11; tick(); set_idle();
    tick();
    check("ord_first", commit_tag, 1);
    tick();
    check("ord_second", commit_tag, 2);

    // Same-tag ALU/memory writeback: memory wins
    do_reset();
    dispatch(3);
    alu_tag = 3'd3; alu_data = 32'h11; mem_tag = 3'd3; mem_data = 32'h22;
    tick(); set_idle();
    query1 = 3'd3; #1;
    check("tie_ready", q1_ready, 1);
    check("tie_data", q1_data, 32'h22);
    tick(); set_idle();

    // Flush with four busy entries
    do_reset();
    dispatch(4);
    flush = 1'b1; tick(); set_idle();
    check("flush_empty", rob_empty, 1);
    check("flush_tag", disp_tag, 1);
    check("flush_cv", commit_valid, 0);
    tick();

    // Query during same-cycle writeback
    do_reset();
    dispatch(4);
    alu_tag = 3'd4; alu_data = 32'h55; query1 = 3'd4; #1;
`ifdef ROB_BYPASS_EN
    check("byp_ready", q1_ready, 1);
    check("byp_data", q1_data, 32'h55);
`else
    check("byp_ready", q1_ready, 0);
    check("byp_data", q1_data, 0);
`endif
    tick(); set_idle();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst_n      = ($urandom_range(0, 149) != 0);
      pause      = ($urandom_range(0, 99) < 8);
      flush      = ($urandom_range(0, 99) < 3);
      disp_valid = ($urandom_range(0, 99) < 60);
      disp_rd    = 5'($urandom);
      alu_tag    = $urandom_range(0, 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      mem_tag    = $urandom_range(0, 2) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
      alu_data   = $urandom;
      mem_data   = $urandom;
      query1     = 3'($urandom_range(0, 7));
      query2     = 3'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
